// File: rtl/toaster_ctrl.sv
// -----------------------------------------------------------------------------
// toaster_ctrl
//   Sequencing FSM for the toaster datapath. Walks IDLE -> WARMUP -> TOAST ->
//   COOL_DOWN -> IDLE. A single down-counter times each phase. The TOAST phase
//   length scales with the darkness level that was latched when the cycle
//   was accepted. Every output comes from a flop, so no input reaches an
//   output through combinational logic.
//
// Ports
//   clk          rising-edge clock
//   rst_n        async active-low reset
//   start_i      request a toast cycle (sampled in IDLE only)
//   cancel_i     abort an active WARMUP/TOAST phase
//   level_i      darkness level, latched on an accepted start
//   state_o      state code: 00 IDLE, 01 WARMUP, 10 TOAST, 11 COOL_DOWN
//   heater_o     heater enable (WARMUP or TOAST)
//   busy_o       state_o != IDLE
//   done_o       1-cycle pulse on the first COOL_DOWN cycle after a normal TOAST
//   abort_o      1-cycle pulse on the first COOL_DOWN cycle after a cancel
//   remaining_o  cycles left in the current phase, this one included (0 in IDLE)
// -----------------------------------------------------------------------------
module toaster_ctrl #(
  parameter int WARMUP_CYCLES = 8,
  parameter int TOAST_CYCLES  = 16,
  parameter int COOL_CYCLES   = 4,
  parameter int LEVEL_W       = 3,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     cancel_i,
  input  logic [LEVEL_W-1:0]       level_i,
  output logic [1:0]               state_o,
  output logic                     heater_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     abort_o,
  output logic [CNT_W+LEVEL_W-1:0] remaining_o
);

  localparam int CW = CNT_W + LEVEL_W;

  localparam logic [CW-1:0] WARM_LOAD  = CW'(WARMUP_CYCLES);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOL_CYCLES);
  localparam logic [CW-1:0] TOAST_BASE = CW'(TOAST_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_TOAST  = 2'b10,
    ST_COOL   = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 heater_q, heater_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;

  logic [CW-1:0]        toast_load;
  logic                 cnt_last;

  // The product uses the full CNT_W+LEVEL_W width, so the largest base times
  // the largest (level+1) still fits without wrapping.
  assign toast_load = TOAST_BASE * (CW'(level_q) + CW'(1));
  assign cnt_last   = (cnt_q == CW'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      level_q  <= '0;
      heater_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      heater_q <= heater_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // start together with cancel is treated as no request at all.
        if (start_i && !cancel_i) begin
          state_d = ST_WARMUP;
          cnt_d   = WARM_LOAD;
          level_d = level_i;
        end
      end

      ST_WARMUP: begin
        if (cancel_i) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else if (cnt_last) begin
          state_d = ST_TOAST;
          cnt_d   = toast_load;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_TOAST: begin
        // Cancel takes priority even on the final TOAST cycle.
        if (cancel_i || cnt_last) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_COOL: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values, registered above)
  // ---------------------------------------------------------------------------
  always_comb begin
    heater_d = (state_d == ST_WARMUP) || (state_d == ST_TOAST);
    busy_d   = (state_d != ST_IDLE);
    abort_d  = cancel_i && ((state_q == ST_WARMUP) || (state_q == ST_TOAST));
    done_d   = (state_q == ST_TOAST) && cnt_last && !cancel_i;
  end

  assign state_o     = state_q;
  assign heater_o    = heater_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign remaining_o = cnt_q;

endmodule

// File: tb/tb_toaster_ctrl.sv
// -----------------------------------------------------------------------------
// tb_toaster_ctrl
//   Directed bench for toaster_ctrl with default parameters (8/16/4 cycles,
//   3-bit level, 11-bit remaining count). A vector table covers one
//   cancelled cycle. Hand-written sequences cover the following cases:
//     - a nominal run
//     - a level-7 run
//     - a cancel in WARMUP
//     - a cancel on the last TOAST cycle
//     - start held high
//     - an async reset in the middle of TOAST
// -----------------------------------------------------------------------------
module tb_toaster_ctrl;

  localparam int CW = 11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WARM = 2'b01;
  localparam logic [1:0] S_TOST = 2'b10;
  localparam logic [1:0] S_COOL = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          cancel_i;
  logic [2:0]    level_i;
  logic [1:0]    state_o;
  logic          heater_o;
  logic          busy_o;
  logic          done_o;
  logic          abort_o;
  logic [CW-1:0] remaining_o;

  int n_cmp  = 0;
  int n_fail = 0;

  toaster_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .cancel_i    (cancel_i),
    .level_i     (level_i),
    .state_o     (state_o),
    .heater_o    (heater_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .abort_o     (abort_o),
    .remaining_o (remaining_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          cancel;
    logic [2:0]    level;
    logic [1:0]    st;
    logic          heater;
    logic          busy;
    logic          done;
    logic          abort;
    logic [CW-1:0] rem;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge.
  // Outputs are read at the same moment, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] pack_out();
    return {state_o, heater_o, busy_o, done_o, abort_o, remaining_o};
  endfunction

  function automatic vec_t mk(input logic s, input logic c, input logic [2:0] l,
                              input logic [1:0] st, input logic h, input logic b,
                              input logic d, input logic a, input int rem);
    vec_t v;
    v.start = s; v.cancel = c; v.level = l; v.st = st; v.heater = h;
    v.busy = b; v.done = d; v.abort = a; v.rem = CW'(rem);
    return v;
  endfunction

  // Waits until state_o == st (and remaining_o == rem when rem >= 0).
  // An expired budget counts as a failed comparison.
  task automatic wait_for(input logic [1:0] st, input int rem, input int budget,
                          input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (n < budget && !hit) begin
      if (state_o == st && (rem < 0 || int'(remaining_o) == rem)) hit = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check(name, 32'(hit), 32'd1);
  endtask

  // Counters filled by run_cycle.
  int warm_n, toast_n, cool_n, heat_n, done_n, abort_n, first_toast_rem;
  bit done_pos_ok;

  // Issues a one-cycle start at level lvl.
  // Afterwards level_i is set to a different value, to show the running
  // cycle ignores it.
  // Then observes the cycle until the design is idle again.
  task automatic run_cycle(input logic [2:0] lvl);
    logic [1:0] prev;
    warm_n = 0; toast_n = 0; cool_n = 0; heat_n = 0;
    done_n = 0; abort_n = 0; first_toast_rem = -1; done_pos_ok = 1'b1;
    start_i = 1'b1;
    level_i = lvl;
    tick();
    start_i = 1'b0;
    level_i = ~lvl;
    prev = S_IDLE;
    for (int c = 0; c < 400 && busy_o; c++) begin
      case (state_o)
        S_WARM: warm_n++;
        S_TOST: toast_n++;
        S_COOL: cool_n++;
        default: ;
      endcase
      if (heater_o) heat_n++;
      if (state_o == S_TOST && prev != S_TOST) first_toast_rem = int'(remaining_o);
      if (done_o) begin
        done_n++;
        if (!(state_o == S_COOL && prev == S_TOST && remaining_o == CW'(4)))
          done_pos_ok = 1'b0;
      end
      if (abort_o) abort_n++;
      prev = state_o;
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    level_i  = 3'd0;

    // Table: a level-0 cycle cancelled during the 3rd TOAST cycle.
    // After that: ignored start/cancel in COOL_DOWN, then start&cancel
    // together in IDLE.
    // Each row lists the inputs for one edge and the outputs expected
    // after it.
    tbl[0] = mk(1, 0, 3'd0, S_WARM, 1, 1, 0, 0, 8);
    for (int i = 1; i <= 7; i++) tbl[i] = mk(0, 0, 3'd5, S_WARM, 1, 1, 0, 0, 8 - i);
    tbl[8]  = mk(0, 0, 3'd0, S_TOST, 1, 1, 0, 0, 16);
    tbl[9]  = mk(0, 0, 3'd0, S_TOST, 1, 1, 0, 0, 15);
    tbl[10] = mk(0, 0, 3'd0, S_TOST, 1, 1, 0, 0, 14);
    tbl[11] = mk(0, 1, 3'd0, S_COOL, 0, 1, 0, 1, 4);
    tbl[12] = mk(1, 1, 3'd0, S_COOL, 0, 1, 0, 0, 3);
    tbl[13] = mk(1, 0, 3'd0, S_COOL, 0, 1, 0, 0, 2);
    tbl[14] = mk(0, 1, 3'd0, S_COOL, 0, 1, 0, 0, 1);
    tbl[15] = mk(0, 0, 3'd0, S_IDLE, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 3'd3, S_IDLE, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 3'd0, S_IDLE, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 3'd0, S_IDLE, 0, 0, 0, 0, 0);

    // Reset state.
    tick();
    check("reset_outputs", 32'(pack_out()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_release", 32'(pack_out()), 32'd0);

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      start_i  = tbl[i].start;
      cancel_i = tbl[i].cancel;
      level_i  = tbl[i].level;
      tick();
      check($sformatf("vec%0d", i), 32'(pack_out()),
            32'({tbl[i].st, tbl[i].heater, tbl[i].busy, tbl[i].done, tbl[i].abort, tbl[i].rem}));
    end
    start_i  = 1'b0;
    cancel_i = 1'b0;

    // Nominal level-0 cycle.
    run_cycle(3'd0);
    check("nom_warm_cycles",  32'(warm_n),  32'd8);
    check("nom_toast_cycles", 32'(toast_n), 32'd16);
    check("nom_cool_cycles",  32'(cool_n),  32'd4);
    check("nom_heater_cycles", 32'(heat_n), 32'd24);
    check("nom_done_pulses",  32'(done_n),  32'd1);
    check("nom_done_position", 32'(done_pos_ok), 32'd1);
    check("nom_abort_pulses", 32'(abort_n), 32'd0);
    check("nom_back_idle",    32'(pack_out()), 32'd0);

    // Level 7: TOAST becomes 16*8 = 128 cycles.
    // level_i changes after the start must be ignored.
    tick();
    run_cycle(3'd7);
    check("l7_toast_cycles",   32'(toast_n), 32'd128);
    check("l7_first_toast_rem", 32'(first_toast_rem), 32'd128);
    check("l7_heater_cycles",  32'(heat_n), 32'd136);
    check("l7_done_pulses",    32'(done_n), 32'd1);

    // Cancel during WARMUP.
    tick();
    start_i = 1'b1;
    level_i = 3'd1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("warm_cancel_out", 32'(pack_out()), 32'({S_COOL, 1'b0, 1'b1, 1'b0, 1'b1, 11'd4}));
    wait_for(S_IDLE, -1, 10, "warm_cancel_to_idle");

    // Cancel on the final TOAST cycle: the cancel wins over done.
    tick();
    start_i = 1'b1;
    level_i = 3'd0;
    tick();
    start_i = 1'b0;
    wait_for(S_TOST, 1, 40, "reach_last_toast");
    cancel_i = 1'b1;
    tick();
    cancel_i = 1'b0;
    check("last_toast_cancel", 32'(pack_out()), 32'({S_COOL, 1'b0, 1'b1, 1'b0, 1'b1, 11'd4}));
    tick();
    check("last_toast_no_late_done", 32'({done_o, abort_o}), 32'd0);
    wait_for(S_IDLE, -1, 10, "last_cancel_to_idle");

    // Start held high.
    // Expected period is 8 W + 16 T + 4 C + 1 IDLE = 29 cycles.
    start_i = 1'b1;
    level_i = 3'd0;
    for (int k = 0; k < 58; k++) begin
      int p;
      logic [1:0] exp_st;
      tick();
      p = k % 29;
      if (p < 8)       exp_st = S_WARM;
      else if (p < 24) exp_st = S_TOST;
      else if (p < 28) exp_st = S_COOL;
      else             exp_st = S_IDLE;
      check($sformatf("held_state_k%0d", k), 32'(state_o), 32'(exp_st));
    end
    start_i = 1'b0;
    wait_for(S_IDLE, -1, 40, "held_drain_idle");

    // Async reset in the middle of TOAST: outputs clear without a clock edge.
    tick();
    start_i = 1'b1;
    level_i = 3'd2;
    tick();
    start_i = 1'b0;
    wait_for(S_TOST, -1, 20, "reach_toast_for_reset");
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(pack_out()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(pack_out()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
